regfile_scoreboard: RTL
=======================

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 Parameter XLEN, default 32, data width of each register.
REQ-002 Parameter AW, default 5, register address width; register count NREGS = 2**AW.
REQ-003 Parameter BYPASS, default 1, enables write-to-read forwarding and busy-clear forwarding.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-low (0 = reset).
REQ-006 regwrite  input  1  writeback enable.
REQ-007 writereg  input  AW  writeback register index.
REQ-008 writedata  input  XLEN  writeback data.
REQ-009 readreg1, readreg2  input  AW each  read port indices.
REQ-010 readdata1, readdata2  output  XLEN each  read port data.
REQ-011 busy1, busy2  output  1 each  pending-write status of readreg1/readreg2.
REQ-012 issue_valid  input  1  marks issue_reg as having a pending write.
REQ-013 issue_reg  input  AW  destination index being issued.
REQ-014 flush  input  1  clears all pending-write marks.
REQ-015 busy_count  output  AW+1  number of registers currently marked busy.

Function
REQ-016 Storage SHALL hold NREGS x XLEN bits plus NREGS busy bits; register 0 SHALL always read 0 and never be stored to or marked busy.
REQ-017 On a rising edge with regwrite=1 and writereg!=0, register[writereg] SHALL take writedata; otherwise contents SHALL hold.
REQ-018 Reads SHALL be combinational: readdataN = register[readregN], or 0 when readregN=0.
REQ-019 With BYPASS=1, when regwrite=1, writereg!=0 and writereg=readregN in the same cycle, readdataN SHALL equal writedata; with BYPASS=0 it SHALL show the old value until the edge.
REQ-020 On a rising edge with issue_valid=1 and issue_reg!=0, busy[issue_reg] SHALL set to 1.
REQ-021 On a rising edge with regwrite=1 and writereg!=0, busy[writereg] SHALL clear to 0 unless set by REQ-020 in the same edge.
REQ-022 Simultaneous issue and writeback to the same register: issue SHALL win; busy stays 1 and data is still written.
REQ-023 flush=1 at a rising edge SHALL clear all busy bits, overriding same-edge issue; register data writes SHALL proceed unaffected.
REQ-024 busyN SHALL be busy[readregN] (0 for index 0); with BYPASS=1, busyN SHALL read 0 when regwrite=1 and writereg=readregN!=0 that cycle.
REQ-025 busy_count SHALL be the registered popcount of busy bits, updated the cycle after the edge that changes them (no forwarding), range 0..NREGS-1.
REQ-026 Writeback to a register not marked busy SHALL be legal and write data normally.
REQ-027 Issue to an already-busy register SHALL leave it busy with no count change.

Reset
REQ-028 While rst=0, all registers SHALL be 0, all busy bits 0, busy_count 0, independent of clk.
REQ-029 Reset asserted mid-operation SHALL discard all pending writes and busy state immediately; first update occurs on the first rising edge with rst=1.
REQ-030 After reset, readdata1/2 SHALL be 0 and busy1/2 SHALL be 0 for all indices.

Verification
REQ-031 Reset then write 0xDEADBEEF to r5, read r5 next cycle -> readdata1=0xDEADBEEF, busy1=0.
REQ-032 Write 0x12345678 to r0, read r0 -> readdata1=0, busy_count unchanged.
REQ-033 BYPASS=1: same cycle regwrite r7=0xA5A5A5A5 with readreg2=7 -> readdata2=0xA5A5A5A5 before the edge; BYPASS=0 -> old value.
REQ-034 Issue r3, r4, r3 on three edges -> busy_count 1, 2, 2; writeback r3 -> busy_count 1, busy1 (readreg1=3)=0.
REQ-035 Same edge issue r9 and writeback r9=0x1 -> busy[9]=1, register 9 = 0x1; next edge flush with issue r10 -> busy_count 0.
REQ-036 Issue r1..r31 on consecutive edges -> busy_count 31; assert rst=0 between edges -> busy_count 0 and all readdata 0 immediately.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Register file with a per-register pending-write scoreboard.
// Two combinational read ports and one writeback port. Each register has a
// busy bit that is set on issue and cleared on writeback, and a registered
// count of busy registers is provided. Register 0 is hardwired to zero and
// is never marked busy. Optional forwarding presents same-cycle writeback
// data and busy-clear on the read ports.
module regfile_scoreboard #(
    parameter int XLEN   = 32,
    parameter int AW     = 5,
    parameter int BYPASS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            regwrite,
    input  logic [AW-1:0]   writereg,
    input  logic [XLEN-1:0] writedata,
    input  logic [AW-1:0]   readreg1,
    input  logic [AW-1:0]   readreg2,
    output logic [XLEN-1:0] readdata1,
    output logic [XLEN-1:0] readdata2,
    output logic            busy1,
    output logic            busy2,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_reg,
    input  logic            flush,
    output logic [AW:0]     busy_count
);

    localparam int NREGS = 2 ** AW;
    localparam bit BYP   = (BYPASS != 0);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [AW:0]      busy_count_q;
    logic [AW:0]      busy_count_d;

    // A writeback only counts when it targets a real register and the block
    // is out of reset; this keeps every output at zero while rst is low.
    logic wr_en;
    logic iss_en;
    assign wr_en  = rst && regwrite && (writereg != '0);
    assign iss_en = issue_valid && (issue_reg != '0);

    // Next-state for register data, busy bits and the busy population count.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        regs_d       = regs_q;
        busy_d       = busy_q;
        busy_count_d = '0;

        if (wr_en) begin
            regs_d[writereg] = writedata;
            busy_d[writereg] = 1'b0;
        end
        // Issue is applied after writeback so it wins on the same index.
        if (iss_en) begin
            busy_d[issue_reg] = 1'b1;
        end
        // Flush clears all marks, including a same-edge issue; data writes
        // above are untouched.
        if (flush) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;

        for (int i = 0; i < NREGS; i++) begin
            busy_count_d = busy_count_d + (AW+1)'(busy_d[i]);
        end
    end

    // State registers; all storage clears asynchronously on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the data array is reset as well, because every register
            // must read zero while reset is held; this rules out a RAM macro.
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q       <= '0;
            busy_count_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so all state updates together
            // at the edge regardless of statement order.
            regs_q       <= regs_d;
            busy_q       <= busy_d;
            busy_count_q <= busy_count_d;
        end
    end

    // Read port 1: zero for r0, forwarded writeback data when enabled.
    always_comb begin
        readdata1 = '0;
        busy1     = 1'b0;
        if (readreg1 != '0) begin
            if (BYP && wr_en && (writereg == readreg1)) begin
                readdata1 = writedata;
                busy1     = 1'b0;
            end else begin
                readdata1 = regs_q[readreg1];
                busy1     = busy_q[readreg1];
            end
        end
    end

    // Read port 2: identical to port 1.
    always_comb begin
        readdata2 = '0;
        busy2     = 1'b0;
        if (readreg2 != '0) begin
            if (BYP && wr_en && (writereg == readreg2)) begin
                readdata2 = writedata;
                busy2     = 1'b0;
            end else begin
                readdata2 = regs_q[readreg2];
                busy2     = busy_q[readreg2];
            end
        end
    end

    assign busy_count = busy_count_q;

endmodule
